// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage.
// Holds the ALU opcode encodings, the register-shift type encodings and
// the bit positions of the N, Z, C and V flags inside the 4-bit status word.
package exe_stage_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/exe_stage_val2_generator.sv
// Second-operand generator (purely combinational).
// Ports:
//   val_rm_i        register operand to be shifted
//   shift_operand_i 12-bit shifter field from the instruction
//   imm_i           select the rotated 8-bit immediate
//   mem_en_i        load/store: use the 12-bit field as an unsigned offset
//   val2_o          resulting second operand
module val2_generator
  import exe_stage_pkg::*;
(
  input  logic [31:0] val_rm_i,
  input  logic [11:0] shift_operand_i,
  input  logic        imm_i,
  input  logic        mem_en_i,
  output logic [31:0] val2_o
);

  // Rotate right by duplicating the word; n = 0 returns x unchanged.
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  logic [4:0]  rot_amt;
  logic [4:0]  sh_amt;
  logic [31:0] imm32;
  shift_t      sh_type;

  assign rot_amt = {shift_operand_i[11:8], 1'b0};
  assign sh_amt  = shift_operand_i[11:7];
  assign imm32   = {24'b0, shift_operand_i[7:0]};
  assign sh_type = shift_t'(shift_operand_i[6:5]);

  always_comb begin
    val2_o = val_rm_i;
    if (imm_i) begin
      val2_o = ror32(imm32, rot_amt);
    end else if (mem_en_i) begin
      val2_o = {20'b0, shift_operand_i};
    end else begin
      case (sh_type)
        SH_LSL:  val2_o = val_rm_i << sh_amt;
        SH_LSR:  val2_o = val_rm_i >> sh_amt;
        SH_ASR:  val2_o = $unsigned($signed(val_rm_i) >>> sh_amt);
        SH_ROR:  val2_o = ror32(val_rm_i, sh_amt);
        default: val2_o = val_rm_i;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: forms the second operand, runs the ALU, computes the
// branch target, and owns the NZCV status register and the EX/MEM register.
// Ports:
//   CLK, RST, Freeze                       clock, sync active-high reset, global hold
//   WB_EN_In, MEM_R_EN_In, MEM_W_EN_In     control bits from ID/EX
//   B_In, S_In                             branch; update status flags
//   EXE_CMD_In                             ALU opcode
//   PC_In, Val_Rn_In, Val_Rm_In            PC+4 and operand values
//   imm_In, Shift_operand_In               second-operand selection / shifter field
//   Signed_imm_24_In, Dest_In, SR_In       branch offset, destination, decode-time NZCV
//   Branch_Taken, Branch_Addr              combinational branch outputs
//   SR                                     status register {N,Z,C,V}
//   *_Out                                  registered EX/MEM fields
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        Freeze,
  input  logic        WB_EN_In,
  input  logic        MEM_R_EN_In,
  input  logic        MEM_W_EN_In,
  input  logic        B_In,
  input  logic        S_In,
  input  logic [3:0]  EXE_CMD_In,
  input  logic [31:0] PC_In,
  input  logic [31:0] Val_Rn_In,
  input  logic [31:0] Val_Rm_In,
  input  logic        imm_In,
  input  logic [11:0] Shift_operand_In,
  input  logic [23:0] Signed_imm_24_In,
  input  logic [3:0]  Dest_In,
  input  logic [3:0]  SR_In,
  output logic        Branch_Taken,
  output logic [31:0] Branch_Addr,
  output logic [3:0]  SR,
  output logic        WB_EN_Out,
  output logic        MEM_R_EN_Out,
  output logic        MEM_W_EN_Out,
  output logic [31:0] ALU_Res_Out,
  output logic [31:0] Val_Rm_Out,
  output logic [3:0]  Dest_Out
);

  logic [31:0] val2;
  logic [31:0] alu_res;
  logic [3:0]  alu_flags;
  logic [32:0] sum;
  logic        c_new;
  logic        v_new;
  logic        op_known;

  logic [3:0]  sr_q, sr_d;
  logic        wb_q, wb_d, mr_q, mr_d, mw_q, mw_d;
  logic [31:0] res_q, res_d, rm_q, rm_d;
  logic [3:0]  dest_q, dest_d;

  val2_generator u_val2 (
    .val_rm_i        (Val_Rm_In),
    .shift_operand_i (Shift_operand_In),
    .imm_i           (imm_In),
    .mem_en_i        (MEM_R_EN_In | MEM_W_EN_In),
    .val2_o          (val2)
  );

  assign Branch_Taken = B_In;
  assign Branch_Addr  = PC_In + {{6{Signed_imm_24_In[23]}}, Signed_imm_24_In, 2'b00};

  // Subtraction is done as Rn + ~Val2 + carry so that the carry-out is NOT borrow.
  always_comb begin
    sum      = '0;
    alu_res  = '0;
    c_new    = sr_q[FLAG_C];
    v_new    = sr_q[FLAG_V];
    op_known = 1'b1;
    case (EXE_CMD_In)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_ADD, CMD_ADC: begin
        sum     = {1'b0, Val_Rn_In} + {1'b0, val2} +
                  {32'b0, (EXE_CMD_In == CMD_ADC) & SR_In[FLAG_C]};
        alu_res = sum[31:0];
        c_new   = sum[32];
        v_new   = (Val_Rn_In[31] == val2[31]) && (alu_res[31] != Val_Rn_In[31]);
      end
      CMD_SUB, CMD_SBC: begin
        sum     = {1'b0, Val_Rn_In} + {1'b0, ~val2} +
                  {32'b0, (EXE_CMD_In == CMD_SUB) | SR_In[FLAG_C]};
        alu_res = sum[31:0];
        c_new   = sum[32];
        v_new   = (Val_Rn_In[31] != val2[31]) && (alu_res[31] != Val_Rn_In[31]);
      end
      CMD_AND: alu_res = Val_Rn_In & val2;
      CMD_ORR: alu_res = Val_Rn_In | val2;
      CMD_EOR: alu_res = Val_Rn_In ^ val2;
      default: op_known = 1'b0;
    endcase
    alu_flags = op_known ? {alu_res[31], alu_res == 32'd0, c_new, v_new} : sr_q;
  end

  // Branches are squashed on their way into EX/MEM and never touch the flags.
  assign wb_d   = WB_EN_In & ~B_In;
  assign mr_d   = MEM_R_EN_In & ~B_In;
  assign mw_d   = MEM_W_EN_In & ~B_In;
  assign res_d  = alu_res;
  assign rm_d   = Val_Rm_In;
  assign dest_d = Dest_In;
  assign sr_d   = (S_In && !B_In) ? alu_flags : sr_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sr_q   <= '0;
      wb_q   <= 1'b0;
      mr_q   <= 1'b0;
      mw_q   <= 1'b0;
      res_q  <= '0;
      rm_q   <= '0;
      dest_q <= '0;
    end else if (!Freeze) begin
      sr_q   <= sr_d;
      wb_q   <= wb_d;
      mr_q   <= mr_d;
      mw_q   <= mw_d;
      res_q  <= res_d;
      rm_q   <= rm_d;
      dest_q <= dest_d;
    end
  end

  assign SR           = sr_q;
  assign WB_EN_Out    = wb_q;
  assign MEM_R_EN_Out = mr_q;
  assign MEM_W_EN_Out = mw_q;
  assign ALU_Res_Out  = res_q;
  assign Val_Rm_Out   = rm_q;
  assign Dest_Out     = dest_q;

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

  logic        CLK = 1'b0;
  logic        RST, Freeze, WB_EN_In, MEM_R_EN_In, MEM_W_EN_In, B_In, S_In, imm_In;
  logic [3:0]  EXE_CMD_In, Dest_In, SR_In;
  logic [31:0] PC_In, Val_Rn_In, Val_Rm_In;
  logic [11:0] Shift_operand_In;
  logic [23:0] Signed_imm_24_In;
  logic        Branch_Taken, WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out;
  logic [31:0] Branch_Addr, ALU_Res_Out, Val_Rm_Out;
  logic [3:0]  SR, Dest_Out;

  always #5 CLK = ~CLK;

  exe_stage dut (
    .CLK(CLK), .RST(RST), .Freeze(Freeze),
    .WB_EN_In(WB_EN_In), .MEM_R_EN_In(MEM_R_EN_In), .MEM_W_EN_In(MEM_W_EN_In),
    .B_In(B_In), .S_In(S_In), .EXE_CMD_In(EXE_CMD_In), .PC_In(PC_In),
    .Val_Rn_In(Val_Rn_In), .Val_Rm_In(Val_Rm_In), .imm_In(imm_In),
    .Shift_operand_In(Shift_operand_In), .Signed_imm_24_In(Signed_imm_24_In),
    .Dest_In(Dest_In), .SR_In(SR_In),
    .Branch_Taken(Branch_Taken), .Branch_Addr(Branch_Addr), .SR(SR),
    .WB_EN_Out(WB_EN_Out), .MEM_R_EN_Out(MEM_R_EN_Out), .MEM_W_EN_Out(MEM_W_EN_Out),
    .ALU_Res_Out(ALU_Res_Out), .Val_Rm_Out(Val_Rm_Out), .Dest_Out(Dest_Out)
  );

  int tests = 0;
  int fails = 0;

  // Reference state of the registered outputs.
  logic [3:0]  m_sr, m_dest;
  logic        m_wb, m_mr, m_mw;
  logic [31:0] m_res, m_rm;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] rn;
    logic [31:0] rm;
    logic        imm;
    logic [11:0] sh;
    logic        mr;
    logic        s;
    logic [3:0]  srin;
    logic [31:0] exp_res;
    logic [3:0]  exp_sr;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ror_ref(input logic [31:0] x, input int n);
    logic [63:0] xx;
    logic [63:0] r;
    xx = {32'b0, x};
    r = (xx >> n) | (xx << (32 - n));
    return r[31:0];
  endfunction

  function automatic logic [31:0] val2_ref(input logic imm, input logic mem,
                                           input logic [31:0] rm, input logic [11:0] sh);
    int n;
    int signed sv;
    if (imm) return ror_ref({24'b0, sh[7:0]}, 2 * int'(sh[11:8]));
    if (mem) return {20'b0, sh};
    n = int'(sh[11:7]);
    case (sh[6:5])
      2'd0: return rm << n;
      2'd1: return rm >> n;
      2'd2: begin sv = rm; sv = sv >>> n; return sv; end
      default: return ror_ref(rm, n);
    endcase
  endfunction

  // ALU reference from the arithmetic definitions: unsigned 64-bit sums for the
  // carry, signed 64-bit sums for the overflow.
  task automatic alu_ref(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                         input logic cin, input logic [3:0] cur,
                         output logic [31:0] res, output logic [3:0] fl);
    longint ua, ub, uc, sa, sb, s;
    logic c, v, arith, known;
    ua = rn; ub = v2; sa = $signed(rn); sb = $signed(v2);
    c = cur[1]; v = cur[0]; arith = 1'b0; known = 1'b1; res = 0; s = 0;
    case (cmd)
      4'b0001: res = v2;
      4'b1001: res = ~v2;
      4'b0010, 4'b0011: begin
        uc = (cmd == 4'b0011) ? longint'(cin) : 0;
        res = 32'(ua + ub + uc);
        c = (ua + ub + uc) > 64'hFFFF_FFFF;
        s = sa + sb + uc; arith = 1'b1;
      end
      4'b0100, 4'b0101: begin
        uc = (cmd == 4'b0101) ? longint'(!cin) : 0;
        res = 32'(ua - ub - uc);
        c = ua >= ub + uc;
        s = sa - sb - uc; arith = 1'b1;
      end
      4'b0110: res = rn & v2;
      4'b0111: res = rn | v2;
      4'b1000: res = rn ^ v2;
      default: known = 1'b0;
    endcase
    if (arith) v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    fl = known ? {res[31], res == 0, c, v} : cur;
  endtask

  task automatic model_step;
    logic [31:0] r;
    logic [3:0]  f;
    if (RST) begin
      m_sr = 0; m_wb = 0; m_mr = 0; m_mw = 0; m_res = 0; m_rm = 0; m_dest = 0;
    end else if (!Freeze) begin
      alu_ref(EXE_CMD_In, Val_Rn_In,
              val2_ref(imm_In, MEM_R_EN_In | MEM_W_EN_In, Val_Rm_In, Shift_operand_In),
              SR_In[1], m_sr, r, f);
      m_wb = WB_EN_In & !B_In; m_mr = MEM_R_EN_In & !B_In; m_mw = MEM_W_EN_In & !B_In;
      m_res = r; m_rm = Val_Rm_In; m_dest = Dest_In;
      if (S_In && !B_In) m_sr = f;
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".SR"}, {28'b0, SR}, {28'b0, m_sr});
    chk({tag, ".ctl"}, {29'b0, WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out}, {29'b0, m_wb, m_mr, m_mw});
    chk({tag, ".res"}, ALU_Res_Out, m_res);
    chk({tag, ".rm"}, Val_Rm_Out, m_rm);
    chk({tag, ".dest"}, {28'b0, Dest_Out}, {28'b0, m_dest});
  endtask

  // Inputs are driven just after a rising edge; combinational outputs are checked
  // mid-cycle, registered ones just after the next rising edge.
  task automatic tick(input string tag);
    logic [31:0] ba;
    #1;
    ba = PC_In + 32'($signed({Signed_imm_24_In, 2'b00}));
    chk({tag, ".taken"}, {31'b0, Branch_Taken}, {31'b0, B_In});
    chk({tag, ".baddr"}, Branch_Addr, ba);
    model_step();
    @(posedge CLK);
    #1;
    check_regs(tag);
  endtask

  task automatic zero_inputs;
    RST = 0; Freeze = 0; WB_EN_In = 0; MEM_R_EN_In = 0; MEM_W_EN_In = 0; B_In = 0;
    S_In = 0; imm_In = 0; EXE_CMD_In = 0; Dest_In = 0; SR_In = 0; PC_In = 0;
    Val_Rn_In = 0; Val_Rm_In = 0; Shift_operand_In = 0; Signed_imm_24_In = 0;
  endtask

  task automatic rand_inputs;
    WB_EN_In = 1'($urandom); MEM_R_EN_In = ($urandom_range(0, 3) == 0);
    MEM_W_EN_In = ($urandom_range(0, 3) == 0); S_In = 1'($urandom);
    imm_In = 1'($urandom); EXE_CMD_In = 4'($urandom); Dest_In = 4'($urandom);
    SR_In = 4'($urandom); PC_In = $urandom; Val_Rn_In = $urandom; Val_Rm_In = $urandom;
    Shift_operand_In = 12'($urandom); Signed_imm_24_In = 24'($urandom);
    if ($urandom_range(0, 7) == 0) Val_Rn_In = 32'hFFFF_FFFF;
    if ($urandom_range(0, 7) == 0) Val_Rn_In = 32'h8000_0000;
  endtask

  logic [31:0] h_res;
  logic [3:0]  h_sr;

  initial begin
    zero_inputs();
    @(posedge CLK); #1;
    RST = 1;
    tick("reset");
    chk("reset.SR0", {28'b0, SR}, 32'd0);
    chk("reset.res0", ALU_Res_Out, 32'd0);
    RST = 0;

    //          cmd    rn             rm             imm sh      mr s  srin   exp_res        exp_sr
    vecs[0]  = '{4'h2, 32'hFFFFFFFF, 32'h00000001, 0, 12'h000, 0, 1, 4'h0, 32'h00000000, 4'b0110};
    vecs[1]  = '{4'h1, 32'h00000000, 32'h00000000, 1, 12'h2FF, 0, 1, 4'h0, 32'hF000000F, 4'b1010};
    vecs[2]  = '{4'h4, 32'h80000000, 32'h00000001, 0, 12'h000, 0, 1, 4'h0, 32'h7FFFFFFF, 4'b0011};
    vecs[3]  = '{4'h2, 32'h00000000, 32'h80000000, 0, 12'h240, 0, 0, 4'h0, 32'hF8000000, 4'b0011};
    vecs[4]  = '{4'h3, 32'h00000001, 32'h00000002, 0, 12'h000, 0, 1, 4'h2, 32'h00000004, 4'b0000};
    vecs[5]  = '{4'h5, 32'h00000005, 32'h00000003, 0, 12'h000, 0, 1, 4'h0, 32'h00000001, 4'b0010};
    vecs[6]  = '{4'h6, 32'hF0F0F0F0, 32'h0F0F0F0F, 0, 12'h000, 0, 1, 4'h0, 32'h00000000, 4'b0110};
    vecs[7]  = '{4'h8, 32'hFFFF0000, 32'h0000FFFF, 0, 12'h420, 0, 1, 4'h0, 32'hFFFF00FF, 4'b1010};
    vecs[8]  = '{4'h7, 32'h12340000, 32'h00005678, 0, 12'h000, 0, 0, 4'h0, 32'h12345678, 4'b1010};
    vecs[9]  = '{4'h9, 32'h00000000, 32'h12345678, 1, 12'h000, 0, 1, 4'h0, 32'hFFFFFFFF, 4'b1010};
    vecs[10] = '{4'h1, 32'h00000000, 32'h00000001, 0, 12'h0E0, 0, 0, 4'h0, 32'h80000000, 4'b1010};
    vecs[11] = '{4'h1, 32'h00000000, 32'h00000003, 0, 12'h200, 0, 0, 4'h0, 32'h00000030, 4'b1010};
    vecs[12] = '{4'h0, 32'h00000005, 32'h00000005, 0, 12'h000, 0, 1, 4'h0, 32'h00000000, 4'b1010};
    vecs[13] = '{4'h2, 32'h00001000, 32'h00000007, 0, 12'hFFF, 1, 0, 4'h0, 32'h00001FFF, 4'b1010};
    vecs[14] = '{4'h5, 32'h7FFFFFFF, 32'hFFFFFFFF, 0, 12'h000, 0, 1, 4'h2, 32'h80000000, 4'b1001};
    vecs[15] = '{4'h3, 32'hFFFFFFFF, 32'h00000000, 0, 12'h000, 0, 1, 4'h2, 32'h00000000, 4'b0110};

    for (int i = 0; i < 16; i++) begin
      zero_inputs();
      EXE_CMD_In = vecs[i].cmd; Val_Rn_In = vecs[i].rn; Val_Rm_In = vecs[i].rm;
      imm_In = vecs[i].imm; Shift_operand_In = vecs[i].sh; MEM_R_EN_In = vecs[i].mr;
      S_In = vecs[i].s; SR_In = vecs[i].srin; WB_EN_In = 1; Dest_In = 4'(i);
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.exp_res", i), ALU_Res_Out, vecs[i].exp_res);
      chk($sformatf("vec%0d.exp_sr", i), {28'b0, SR}, {28'b0, vecs[i].exp_sr});
    end

    // Branch: squashes control bits and leaves SR alone even with S set.
    h_sr = SR;
    zero_inputs();
    B_In = 1; S_In = 1; WB_EN_In = 1; MEM_R_EN_In = 1; MEM_W_EN_In = 1;
    EXE_CMD_In = 4'h2; Val_Rn_In = 32'h5; PC_In = 32'h100; Signed_imm_24_In = 24'hFFFFFE;
    #1;
    chk("br.addr_fixed", Branch_Addr, 32'h000000F8);
    chk("br.taken_fixed", {31'b0, Branch_Taken}, 32'd1);
    tick("br");
    chk("br.ctl0", {29'b0, WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out}, 32'd0);
    chk("br.sr_hold", {28'b0, SR}, {28'b0, h_sr});

    // Establish a known nonzero state, then freeze for three changing cycles.
    zero_inputs();
    EXE_CMD_In = 4'h7; Val_Rn_In = 32'hA5A50000; Val_Rm_In = 32'h00005A5A; S_In = 1;
    WB_EN_In = 1; Dest_In = 4'hC;
    tick("prefrz");
    h_res = ALU_Res_Out; h_sr = SR;
    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      Freeze = 1; S_In = 1; B_In = (k == 1);
      tick($sformatf("frz%0d", k));
      chk($sformatf("frz%0d.res_hold", k), ALU_Res_Out, h_res);
      chk($sformatf("frz%0d.sr_hold", k), {28'b0, SR}, {28'b0, h_sr});
    end
    RST = 1;
    tick("frzrst");
    chk("frzrst.all0", {SR, Dest_Out, WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out} |
        ALU_Res_Out | Val_Rm_Out, 32'd0);
    zero_inputs();

    // Flushed bubble after real traffic.
    EXE_CMD_In = 4'h2; Val_Rn_In = 32'h11; Val_Rm_In = 32'h22; WB_EN_In = 1; MEM_W_EN_In = 1;
    tick("pre_bub");
    zero_inputs();
    tick("bubble");
    chk("bubble.ctl0", {29'b0, WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out}, 32'd0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      RST    = ($urandom_range(0, 49) == 0);
      Freeze = ($urandom_range(0, 7) == 0);
      B_In   = ($urandom_range(0, 7) == 0);
      tick($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
